// File: rtl/nfc_pkg.sv
// nfc_pkg: shared state type, parameter defaults and width helper for the NAND copy sequencer.
package nfc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } nfc_state_t;

    localparam int NFC_ROW_W      = 9;
    localparam int NFC_PAGE_BYTES = 512;

    // Page counters need one extra bit so they can hold NUM_PAGES itself.
    function automatic int nfc_cnt_width(input int row_w);
        return row_w + 1;
    endfunction

endpackage

// File: rtl/nfc_byte_checker.sv
// nfc_byte_checker: counts reader bytes for the page in flight and flags short or overlong pages.
// Only instantiated when NFC_PAGE_CHECK_EN is defined.
module nfc_byte_checker
    import nfc_pkg::*;
#(
    parameter int PAGE_BYTES = NFC_PAGE_BYTES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_valid,
    input  logic i_page_done,
    output logic o_err
);

    localparam int BW = $clog2(PAGE_BYTES + 2);
    localparam logic [BW-1:0] LP_FULL = BW'(PAGE_BYTES);
    localparam logic [BW-1:0] LP_ONE  = BW'(1);

    logic [BW-1:0] r_count;
    logic [BW-1:0] w_count_now;
    logic          w_overflow;
    logic          w_short;

    // A byte arriving in the same cycle as the done pulse still belongs to this page.
    assign w_count_now = i_valid ? (r_count + LP_ONE) : r_count;
    assign w_overflow  = i_valid && (r_count == LP_FULL);
    assign w_short     = i_page_done && (w_count_now != LP_FULL);
    assign o_err       = w_overflow || w_short;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_valid && !w_overflow) begin
            r_count <= w_count_now;
        end
    end

endmodule

// File: rtl/nfc_copy_sequencer.sv
// nfc_copy_sequencer: page-level scheduler pacing the flash-A reader against the flash-B writer.
// Define NFC_PAGE_CHECK_EN to add per-page byte count checking of the reader stream.
module nfc_copy_sequencer
    import nfc_pkg::*;
#(
    parameter int ROW_W      = NFC_ROW_W,
    parameter int NUM_PAGES  = 512,
    parameter int PAGE_BYTES = NFC_PAGE_BYTES,
    parameter int LOOKAHEAD  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_rd_start,
    output logic [ROW_W-1:0] o_rd_row,
    input  logic             i_rd_valid,
    input  logic             i_rd_page_done,
    output logic             o_wr_start,
    output logic [ROW_W-1:0] o_wr_row,
    input  logic             i_wr_page_done,
    input  logic             i_wr_fail,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [ROW_W:0]   o_pages_done
);

    localparam int CW = nfc_cnt_width(ROW_W);
    localparam logic [CW-1:0] LP_NUM = CW'(NUM_PAGES);
    localparam logic [CW-1:0] LP_LA  = CW'(LOOKAHEAD);
    localparam logic [CW-1:0] LP_ONE = CW'(1);

    nfc_state_t       r_state;
    nfc_state_t       w_state_next;
    logic [CW-1:0]    r_rd_cnt;
    logic [CW-1:0]    r_wr_cnt;
    logic [CW-1:0]    r_cmp_cnt;
    logic [CW-1:0]    r_rd_avail;
    logic [CW-1:0]    w_cmp_next;
    logic             r_rd_busy;
    logic             r_wr_busy;
    logic             r_rd_start;
    logic             r_wr_start;
    logic [ROW_W-1:0] r_rd_row;
    logic [ROW_W-1:0] r_wr_row;
    logic             w_running;
    logic             w_start_acc;
    logic             w_rd_done;
    logic             w_wr_done;
    logic             w_wr_fail;
    logic             w_chk_err;
    logic             w_rd_issue;
    logic             w_wr_issue;

    assign w_running   = (r_state == ST_RUN);
    assign w_start_acc = i_start && !w_running;
    assign w_rd_done   = w_running && r_rd_busy && i_rd_page_done;
    assign w_wr_done   = w_running && r_wr_busy && i_wr_page_done;
    assign w_wr_fail   = w_wr_done && i_wr_fail;
    assign w_cmp_next  = (w_wr_done && (r_cmp_cnt < LP_NUM)) ? (r_cmp_cnt + LP_ONE) : r_cmp_cnt;

`ifdef NFC_PAGE_CHECK_EN
    logic w_byte_valid;

    assign w_byte_valid = w_running && r_rd_busy && i_rd_valid;

    nfc_byte_checker #(
        .PAGE_BYTES (PAGE_BYTES)
    ) u_byte_checker (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_rd_issue),
        .i_valid     (w_byte_valid),
        .i_page_done (w_rd_done),
        .o_err       (w_chk_err)
    );
`else
    logic w_unused_rd_valid;

    assign w_unused_rd_valid = i_rd_valid | (PAGE_BYTES == 0);
    assign w_chk_err         = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Completion and failure are decided on the edge that absorbs the done pulse,
    // so done/error appear one cycle after the last wr_page_done.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wr_fail || w_chk_err) begin
                    w_state_next = ST_ERR;
                end else if (w_cmp_next == LP_NUM) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Issue only from registered busy flags; gating on the next state keeps a failing
    // cycle from launching one more page.
    assign w_rd_issue = w_running && (w_state_next == ST_RUN) && !r_rd_busy &&
                        (r_rd_cnt < LP_NUM) && ((r_rd_cnt - r_cmp_cnt) < LP_LA);
    assign w_wr_issue = w_running && (w_state_next == ST_RUN) && !r_wr_busy &&
                        (r_wr_cnt < r_rd_avail);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_start <= 1'b0;
            r_wr_start <= 1'b0;
            r_rd_row   <= '0;
            r_wr_row   <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_cmp_cnt  <= '0;
            r_rd_avail <= '0;
            r_rd_busy  <= 1'b0;
            r_wr_busy  <= 1'b0;
        end else begin
            r_rd_start <= w_rd_issue;
            r_wr_start <= w_wr_issue;
            if (w_start_acc) begin
                r_rd_cnt   <= '0;
                r_wr_cnt   <= '0;
                r_cmp_cnt  <= '0;
                r_rd_avail <= '0;
                r_rd_busy  <= 1'b0;
                r_wr_busy  <= 1'b0;
            end else begin
                // Delayed copy of the read count holds wr_start two cycles behind its rd_start.
                r_rd_avail <= r_rd_cnt;
                if (w_rd_issue) begin
                    r_rd_row  <= r_rd_cnt[ROW_W-1:0];
                    r_rd_cnt  <= r_rd_cnt + LP_ONE;
                    r_rd_busy <= 1'b1;
                end else if (w_rd_done) begin
                    r_rd_busy <= 1'b0;
                end
                if (w_wr_issue) begin
                    r_wr_row  <= r_wr_cnt[ROW_W-1:0];
                    r_wr_cnt  <= r_wr_cnt + LP_ONE;
                    r_wr_busy <= 1'b1;
                end else if (w_wr_done) begin
                    r_wr_busy <= 1'b0;
                end
                r_cmp_cnt <= w_cmp_next;
            end
        end
    end

    assign o_rd_start   = r_rd_start;
    assign o_rd_row     = r_rd_row;
    assign o_wr_start   = r_wr_start;
    assign o_wr_row     = r_wr_row;
    assign o_busy       = w_running;
    assign o_done       = (r_state == ST_DONE);
    assign o_error      = (r_state == ST_ERR);
    assign o_pages_done = r_cmp_cnt;

endmodule

// File: tb/tb_nfc_copy_sequencer.sv
// tb_nfc_copy_sequencer: randomized reader/writer responders with an in-bench page-order model.
// Build with NFC_PAGE_CHECK_EN defined to exercise the byte checker expectations.
module tb_nfc_copy_sequencer;

    localparam int ROW_W      = 9;
    localparam int NUM_PAGES  = 4;
    localparam int PAGE_BYTES = 8;
    localparam int LOOKAHEAD  = 2;
`ifdef NFC_PAGE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_rd_valid = 1'b0;
    logic             i_rd_page_done = 1'b0;
    logic             i_wr_page_done = 1'b0;
    logic             i_wr_fail = 1'b0;
    logic             o_rd_start;
    logic             o_wr_start;
    logic             o_busy;
    logic             o_done;
    logic             o_error;
    logic [ROW_W-1:0] o_rd_row;
    logic [ROW_W-1:0] o_wr_row;
    logic [ROW_W:0]   o_pages_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    nfc_copy_sequencer #(
        .ROW_W      (ROW_W),
        .NUM_PAGES  (NUM_PAGES),
        .PAGE_BYTES (PAGE_BYTES),
        .LOOKAHEAD  (LOOKAHEAD)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .o_rd_start     (o_rd_start),
        .o_rd_row       (o_rd_row),
        .i_rd_valid     (i_rd_valid),
        .i_rd_page_done (i_rd_page_done),
        .o_wr_start     (o_wr_start),
        .o_wr_row       (o_wr_row),
        .i_wr_page_done (i_wr_page_done),
        .i_wr_fail      (i_wr_fail),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_pages_done   (o_pages_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        i_start        = 1'b0;
        i_rd_valid     = 1'b0;
        i_rd_page_done = 1'b0;
        i_wr_page_done = 1'b0;
        i_wr_fail      = 1'b0;
    endtask

    task automatic do_reset(input string why);
        @(negedge i_clk);
        clear_inputs();
        i_rst_n = 1'b0;
        #1;
        check("rst_rd_start", o_rd_start, 0);
        check("rst_wr_start", o_wr_start, 0);
        check("rst_rd_row", o_rd_row, 0);
        check("rst_wr_row", o_wr_row, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_pages_done", o_pages_done, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        $display("[%0t] reset (%s) released", $time, why);
    endtask

    // Reader streams PAGE_BYTES bytes with random gaps then pulses done; writer finishes a
    // page a random time after its read has finished. Expected rows are simply issue order.
    task automatic run_job(input string name, input int fail_page, input int stall_until,
                           input int abort_row, input bit poke_start);
        int rd_seen   = 0;
        int wr_seen   = 0;
        int rd_fin    = 0;
        int completed = 0;
        int rd_bytes  = 0;
        int wr_wait   = 0;
        int first_rd  = -1;
        int cyc       = 0;
        int strays    = 0;
        bit rd_active = 1'b0;
        bit wr_active = 1'b0;
        bit finish    = 1'b0;
        bit failed    = 1'b0;
        bit aborted   = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        $display("[%0t] %s: start pulse", $time, name);
        while (cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            clear_inputs();
            if (finish) break;
            if (cyc == 1) begin
                check("accept_busy", o_busy, 1);
                check("accept_done_clr", o_done, 0);
                check("accept_err_clr", o_error, 0);
                check("accept_pages_clr", o_pages_done, 0);
            end
            if (poke_start && cyc == 5) i_start = 1'b1;
            if (rd_active) begin
                if (rd_bytes < PAGE_BYTES) begin
                    if ($urandom_range(0, 3) != 0) begin
                        i_rd_valid = 1'b1;
                        rd_bytes++;
                    end
                end else begin
                    i_rd_page_done = 1'b1;
                    rd_active = 1'b0;
                    rd_fin++;
                end
            end
            if (wr_active && cyc >= stall_until && rd_fin >= wr_seen) begin
                if (wr_wait > 0) begin
                    wr_wait--;
                end else begin
                    i_wr_page_done = 1'b1;
                    i_wr_fail = (wr_seen - 1 == fail_page);
                    wr_active = 1'b0;
                    completed++;
                    $display("[%0t] %s: wr_page_done page %0d fail=%0d", $time, name, wr_seen - 1, i_wr_fail);
                    if (stall_until > 0 && completed == 1) check("lookahead_hold", rd_seen, LOOKAHEAD);
                    if (i_wr_fail) failed = 1'b1;
                    if (failed || completed == NUM_PAGES) finish = 1'b1;
                end
            end
            if (o_rd_start) begin
                check("rd_row", o_rd_row, rd_seen);
                check("rd_lookahead", (rd_seen - completed) < LOOKAHEAD, 1);
                check("rd_busy", o_busy, 1);
                if (rd_seen == 0) begin
                    first_rd = cyc;
                    check("start_to_rd", cyc, 2);
                end
                rd_seen++;
                rd_active = 1'b1;
                rd_bytes = 0;
                $display("[%0t] %s: rd_start row %0d", $time, name, o_rd_row);
            end
            if (o_wr_start) begin
                check("wr_row", o_wr_row, wr_seen);
                check("wr_after_rd", wr_seen < rd_seen, 1);
                if (wr_seen == 0) check("rd_to_wr", cyc - first_rd, 2);
                wr_seen++;
                wr_active = 1'b1;
                wr_wait = $urandom_range(0, 5);
                $display("[%0t] %s: wr_start row %0d", $time, name, o_wr_row);
                if (wr_seen - 1 == abort_row) begin
                    aborted = 1'b1;
                    break;
                end
            end
        end
        if (aborted) begin
            $display("[%0t] %s: aborting mid page %0d", $time, name, abort_row);
            return;
        end
        check("job_finished", finish, 1);
        if (!finish) return;
        check("end_busy", o_busy, 0);
        check("end_done", o_done, !failed);
        check("end_error", o_error, failed);
        check("end_pages_done", o_pages_done, completed);
        $display("[%0t] %s: end done=%0d error=%0d pages=%0d", $time, name, o_done, o_error, o_pages_done);
        if (!failed) begin
            check("rd_count", rd_seen, NUM_PAGES);
            check("wr_count", wr_seen, NUM_PAGES);
        end else begin
            strays = int'(o_rd_start) + int'(o_wr_start);
            repeat (12) begin
                @(negedge i_clk);
                i_rd_page_done = !i_rd_page_done;
                i_wr_page_done = i_rd_page_done;
                strays += int'(o_rd_start) + int'(o_wr_start);
            end
            clear_inputs();
            check("no_issue_after_err", strays, 0);
            check("pages_hold_after_err", o_pages_done, completed);
            check("error_hold", o_error, 1);
        end
    endtask

    task automatic short_page(input int nbytes);
        int wait_cyc = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        while (!o_rd_start && wait_cyc < 10) begin
            @(negedge i_clk);
            wait_cyc++;
        end
        check("chk_rd_start_seen", o_rd_start, 1);
        for (int b = 0; b < nbytes; b++) begin
            @(negedge i_clk);
            i_rd_valid = 1'b1;
        end
        @(negedge i_clk);
        i_rd_valid = 1'b0;
        check("chk_overflow_err", o_error, CHK_EN && (nbytes > PAGE_BYTES));
        i_rd_page_done = 1'b1;
        @(negedge i_clk);
        i_rd_page_done = 1'b0;
        check("chk_page_err", o_error, CHK_EN && (nbytes != PAGE_BYTES));
        check("chk_page_busy", o_busy, !(CHK_EN && (nbytes != PAGE_BYTES)));
        $display("[%0t] byte check: %0d bytes -> error=%0d", $time, nbytes, o_error);
    endtask

    initial begin
        do_reset("power-on");
        run_job("clean", -1, 0, -1, 1'b0);
        run_job("restart_from_done", -1, 0, -1, 1'b1);
        run_job("lookahead", -1, 100, -1, 1'b0);
        run_job("fail", 1, 0, -1, 1'b0);
        run_job("abort", -1, 0, 2, 1'b0);
        do_reset("abort");
        run_job("after_abort", -1, 0, -1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            run_job("random", -1, 0, -1, 1'($urandom_range(0, 1)));
        end
        do_reset("byte check");
        short_page(PAGE_BYTES - 1);
        do_reset("byte check");
        short_page(PAGE_BYTES);
        do_reset("byte check");
        short_page(PAGE_BYTES + 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
